// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle barrel-less shift controller:
// operation encodings, controller states, the per-cycle step limit and
// the bit-reversal helper used to turn right shifts into left shifts.
package shift_pkg;

  localparam int STEP_MAX = 4;

  typedef enum logic [1:0] {
    OP_SLL     = 2'b00,
    OP_SRL     = 2'b01,
    OP_SLL_ALT = 2'b10,
    OP_SRA     = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Mirror a 32-bit word end to end; right shifts run as left shifts on
  // the mirrored operand and are mirrored back on the way out.
  function automatic logic [31:0] bit_rev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One controller step: left shift by 0..STEP_MAX with the vacated low
// bits filled with a constant fill bit (sign bit for arithmetic shifts).
module shift_step (
  input  logic [31:0] acc,
  input  logic [2:0]  step,
  input  logic        fill,
  output logic [31:0] acc_next
);

  logic [31:0] fill_mask;

  // Shift and OR the fill bit into the low step positions.
  always_comb begin
    fill_mask = ~(32'hFFFF_FFFF << step);
    acc_next  = (acc << step) | ({32{fill}} & fill_mask);
  end

endmodule

// File: rtl/shift_ctrl.sv
// Shift controller: accepts one SLL/SRL/SRA request, performs it at most
// STEP_MAX bits per cycle, then holds the result until it is taken.
module shift_ctrl
  import shift_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  op,
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] result,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [31:0] acc_q,   acc_d;
  logic [4:0]  rem_q,   rem_d;
  logic        right_q, right_d;
  logic        sra_q,   sra_d;
  logic        fill_q,  fill_d;

  op_e         op_sel;
  logic [2:0]  step;
  logic [31:0] acc_step;
  logic        accept;

  assign op_sel = op_e'(op);

  // Bits consumed this cycle: the smaller of what remains and STEP_MAX.
  assign step = (rem_q > 5'(STEP_MAX)) ? 3'(STEP_MAX) : rem_q[2:0];

  shift_step u_step (
    .acc      (acc_step_src()),
    .step     (step),
    .fill     (fill_q & sra_q),
    .acc_next (acc_step)
  );

  function automatic logic [31:0] acc_step_src();
    return acc_q;
  endfunction

  // Handshake-facing outputs are pure decodes of the state register.
  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign resp_valid = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign result     = resp_valid ? (right_q ? bit_rev(acc_q) : acc_q) : '0;
  assign accept     = req_valid && req_ready && !flush;

  // Next-state and datapath update; flush overrides everything else.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path infers a latch.
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    right_d = right_q;
    sra_d   = sra_q;
    fill_d  = fill_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          right_d = (op_sel == OP_SRL) || (op_sel == OP_SRA);
          sra_d   = (op_sel == OP_SRA);
          fill_d  = (op_sel == OP_SRA) && data_in[31];
          rem_d   = shamt;
          acc_d   = op[0] ? bit_rev(data_in) : data_in;
          state_d = (shamt == 5'd0) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d = acc_step;
        rem_d = rem_q - {2'b00, step};
        if (rem_d == 5'd0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
    end
  end

  // State and operand registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      right_q <= 1'b0;
      sra_q   <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      right_q <= right_d;
      sra_q   <= sra_d;
      fill_q  <= fill_d;
    end
  end

endmodule

// File: tb/tb_shift_ctrl.sv
// Bench for shift_ctrl: an arithmetic reference model tracks what the
// outputs must be every cycle, and directed transactions pin literal
// results and latencies.
module tb_shift_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  shift_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op         (op),
    .data_in    (data_in),
    .shamt      (shamt),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .result     (result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result straight from the shift definitions.
  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d,
                                            input logic [4:0] s);
    logic [31:0] r;
    case (o)
      2'b01:   r = d >> s;
      2'b11:   r = $signed(d) >>> s;
      default: r = d << s;
    endcase
    return r;
  endfunction

  // Transaction-level model: busy cycles remaining, pending response, value.
  bit          m_busy;
  bit          m_resp;
  int          m_cnt;
  logic [31:0] m_res = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_resp <= 1'b0;
      m_cnt  <= 0;
    end else if (flush) begin
      m_busy <= 1'b0;
      m_resp <= 1'b0;
      m_cnt  <= 0;
    end else if (m_resp) begin
      if (resp_ready) begin
        m_resp <= 1'b0;
        m_busy <= 1'b0;
      end
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_resp <= 1'b1;
    end else if (req_valid) begin
      m_busy <= 1'b1;
      m_res  <= ref_shift(op, data_in, shamt);
      m_cnt  <= (int'(shamt) + 3) / 4;
      if (shamt == 5'd0) m_resp <= 1'b1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_busy));
    check("resp_valid", 32'(resp_valid), 32'(m_resp));
    check("req_ready", 32'(req_ready), 32'(!m_busy && !rst));
    if (m_resp) check("result", result, m_res);
  end

  task automatic step_clk();
    @(posedge clk);
    #2;
  endtask

  // Count cycles from the accept edge to the first resp_valid cycle.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      step_clk();
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] d,
                        input logic [4:0] s, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    req_valid = 1'b1;
    op        = o;
    data_in   = d;
    shamt     = s;
    step_clk();
    req_valid = 1'b0;
    op        = 2'b10;
    data_in   = 32'hDEAD_BEEF;
    shamt     = 5'd7;
    wait_resp(lat);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_result"}, result, exp_res);
    step_clk();
    check({name, "_released"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int lat;
    rst        = 1'b1;
    req_valid  = 1'b0;
    op         = 2'b00;
    data_in    = '0;
    shamt      = '0;
    flush      = 1'b0;
    resp_ready = 1'b1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_result", result, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 check("post_rst_req_ready", 32'(req_ready), 32'd1);
    step_clk();

    run_op("sll31",   2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 9);
    run_op("sra4",    2'b11, 32'h8000_0000, 5'd4,  32'hF800_0000, 2);
    run_op("srl4",    2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000, 2);
    run_op("sra0",    2'b11, 32'h1234_5678, 5'd0,  32'h1234_5678, 1);
    run_op("op10",    2'b10, 32'h0000_00F0, 5'd8,  32'h0000_F000, 3);
    run_op("sra31",   2'b11, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF, 9);
    run_op("sra17",   2'b11, 32'h7FFF_0000, 5'd17, 32'h0000_3FFF, 6);
    run_op("srl1",    2'b01, 32'hFFFF_FFFF, 5'd1,  32'h7FFF_FFFF, 2);
    run_op("sll3",    2'b00, 32'hA5A5_A5A5, 5'd3,  32'h2D2D_2D28, 2);

    // Backpressure: result held three cycles while new requests are ignored.
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    op         = 2'b00;
    data_in    = 32'h0000_0003;
    shamt      = 5'd5;
    step_clk();
    wait_resp(lat);
    check("bp_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 3; i++) begin
      data_in = 32'h1111_1111 * (i + 1);
      step_clk();
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_result", result, 32'h0000_0060);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    step_clk();
    check("bp_no_same_cycle_accept", 32'(busy), 32'd0);
    req_valid = 1'b0;
    step_clk();

    // Flush in IDLE blocks an accept.
    req_valid = 1'b1;
    flush     = 1'b1;
    step_clk();
    check("flush_idle_busy", 32'(busy), 32'd0);
    req_valid = 1'b0;
    flush     = 1'b0;

    // Flush in the second BUSY cycle of a long SLL.
    req_valid = 1'b1;
    op        = 2'b00;
    data_in   = 32'h0000_0001;
    shamt     = 5'd20;
    step_clk();
    req_valid = 1'b0;
    step_clk();
    check("flush_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    step_clk();
    flush = 1'b0;
    check("flush_idle_after", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step_clk();
      check("flush_no_resp", 32'(resp_valid), 32'd0);
    end
    run_op("post_flush", 2'b01, 32'h0000_0100, 5'd8, 32'h0000_0001, 3);

    // Asynchronous reset in the middle of BUSY.
    req_valid = 1'b1;
    op        = 2'b00;
    data_in   = 32'h0000_0001;
    shamt     = 5'd31;
    step_clk();
    req_valid = 1'b0;
    step_clk();
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd0);
    check("arst_resp_valid", 32'(resp_valid), 32'd0);
    check("arst_result", result, 32'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step_clk();
      check("arst_no_resp", 32'(resp_valid), 32'd0);
    end
    run_op("post_rst", 2'b00, 32'h0000_000F, 5'd4, 32'h0000_00F0, 2);

    repeat (2) step_clk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
